// File: rtl/retospect_neuro_pkg.sv
// Shared sizing and arithmetic helpers for the neurochip cells (LIF cell, clockbox).
// Keeps configuration-chain length bookkeeping identical across every block.
package retospect_neuro_pkg;

  function automatic int sel_bits(input int n_clk);
    return (n_clk > 1) ? $clog2(n_clk) : 1;
  endfunction

  function automatic int cfg_bits(input int n_in, input int w_bits,
                                  input int ut_bits, input int s_bits);
    return n_in * w_bits + ut_bits + s_bits;
  endfunction

  // Clamp a signed value into the range of a 'bits'-wide two's complement field.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/retospect_cfg_chain.sv
// Serial configuration shift register: bits enter at the MSB and leave from the LSB,
// one bit per edge while shift_en is high; the owner gates shift_en for reset priority.
module retospect_cfg_chain #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out
);

  logic [WIDTH-1:0] r_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits <= '0;
    end else if (shift_en) begin
      r_bits <= {ser_in, r_bits[WIDTH-1:1]};
    end
  end

  assign par_out = r_bits;
  assign ser_out = r_bits[0];

endmodule

// File: rtl/retospect_lif_cell.sv
// Leaky integrate-and-fire cell with daisy-chained weight/threshold/decay configuration.
// One-cycle registered spike; saturating potential, clockbus-selected decay, optional refractory.
module retospect_lif_cell
  import retospect_neuro_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int W_BITS   = 3,
  parameter int UT_BITS  = 4,
  parameter int POT_BITS = 6,
  parameter int N_CLK    = 8,
  parameter int REFRACT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             config_en,
  input  logic             reset_nn,
  input  logic             bs_in,
  output logic             bs_out,
  input  logic [N_CLK-1:0] clockbus,
  input  logic [N_IN-1:0]  spike_in,
  output logic             spike_out
);

  localparam int SEL_BITS = sel_bits(N_CLK);
  localparam int CFG_BITS = cfg_bits(N_IN, W_BITS, UT_BITS, SEL_BITS);
  localparam int SUM_W    = POT_BITS + $clog2(N_IN) + 1;
  localparam int CMP_W    = (POT_BITS > UT_BITS + 1) ? POT_BITS : UT_BITS + 1;
  localparam int RC_W     = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int UT_LSB   = SEL_BITS;
  localparam int W_LSB    = SEL_BITS + UT_BITS;
  localparam logic signed [SUM_W-1:0] P_ONE = SUM_W'(1);

  logic [CFG_BITS-1:0]        w_cfg;
  logic signed [W_BITS-1:0]   w_wt [N_IN];
  logic [UT_BITS-1:0]         w_ut;
  logic [SEL_BITS-1:0]        w_sel;
  logic                       w_tick;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [SUM_W-1:0]    w_p;
  logic signed [SUM_W-1:0]    w_p_dec;
  logic signed [POT_BITS-1:0] w_p_sat;
  logic signed [CMP_W-1:0]    w_p_cmp;
  logic signed [CMP_W-1:0]    w_ut_cmp;
  logic                       w_fire;

  logic signed [POT_BITS-1:0] r_pot;
  logic                       r_spike;
  logic [RC_W-1:0]            r_refr;

  retospect_cfg_chain #(
    .WIDTH (CFG_BITS)
  ) u_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (config_en & ~reset_nn),
    .ser_in   (bs_in),
    .par_out  (w_cfg),
    .ser_out  (bs_out)
  );

  // w[0] sits at the MSB end of the chain so it is the first field bs_in fills.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_wt[i] = w_cfg[W_LSB + (N_IN - 1 - i) * W_BITS +: W_BITS];
    end
  end

  assign w_ut  = w_cfg[UT_LSB +: UT_BITS];
  assign w_sel = w_cfg[0 +: SEL_BITS];

  // A selector beyond the populated clockbus lines matches nothing, so no decay.
  always_comb begin
    w_tick = 1'b0;
    for (int k = 0; k < N_CLK; k++) begin
      if (SEL_BITS'(k) == w_sel) w_tick = clockbus[k];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) w_sum = w_sum + SUM_W'(w_wt[i]);
    end
    if (r_refr != '0) w_sum = '0;
  end

  assign w_p = SUM_W'(r_pot) + w_sum;

  always_comb begin
    w_p_dec = w_p;
    if (w_tick) begin
      if (w_p > 0)      w_p_dec = w_p - P_ONE;
      else if (w_p < 0) w_p_dec = w_p + P_ONE;
    end
  end

  assign w_p_sat  = POT_BITS'(sat_signed(32'(w_p_dec), POT_BITS));
  assign w_p_cmp  = CMP_W'(w_p_sat);
  assign w_ut_cmp = CMP_W'($signed({1'b0, w_ut}));
  assign w_fire   = (r_refr == '0) && (w_p_cmp >= w_ut_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pot   <= '0;
      r_spike <= 1'b0;
      r_refr  <= '0;
    end else if (reset_nn) begin
      r_pot   <= '0;
      r_spike <= 1'b0;
      r_refr  <= '0;
    end else if (config_en) begin
      r_spike <= 1'b0;
    end else if (w_fire) begin
      r_spike <= 1'b1;
      r_pot   <= '0;
      r_refr  <= RC_W'(REFRACT);
    end else begin
      r_spike <= 1'b0;
      r_pot   <= w_p_sat;
      if (r_refr != '0) r_refr <= r_refr - 1'b1;
    end
  end

  assign spike_out = r_spike;

endmodule

// File: tb/tb_retospect_lif_cell.sv
// Bench for retospect_lif_cell: two cells (no refractory / refractory 2) share all inputs;
// a bit-queue chain model plus integer neuron model is compared every cycle, with literal spot checks.
module tb_retospect_lif_cell;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       config_en;
  logic       reset_nn;
  logic       bs_in;
  logic [7:0] clockbus;
  logic [3:0] spike_in;
  logic       bs_out0, bs_out1, spk0, spk1;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  retospect_lif_cell #(.REFRACT(0)) dut (
    .clk(clk), .rst_n(rst_n), .config_en(config_en), .reset_nn(reset_nn),
    .bs_in(bs_in), .bs_out(bs_out0), .clockbus(clockbus), .spike_in(spike_in),
    .spike_out(spk0)
  );

  retospect_lif_cell #(.REFRACT(2)) dut_r (
    .clk(clk), .rst_n(rst_n), .config_en(config_en), .reset_nn(reset_nn),
    .bs_in(bs_in), .bs_out(bs_out1), .clockbus(clockbus), .spike_in(spike_in),
    .spike_out(spk1)
  );

  // Model: chain as 19 bit slots, slot 0 = first bit in (w0 MSB), slot 18 = decay_sel LSB.
  int m_chain [19];
  int m_pot [2];
  int m_spk [2];
  int m_refr [2];
  int m_refract [2] = '{0, 2};
  int m_ut, m_sel, m_sum, m_p;

  function automatic int field(input int pos, input int len);
    int v;
    v = 0;
    for (int b = pos; b < pos + len; b++) v = v * 2 + m_chain[b];
    return v;
  endfunction

  function automatic int weight(input int i);
    int v;
    v = field(i * 3, 3);
    return (v >= 4) ? v - 8 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 19; j++) m_chain[j] = 0;
      for (int c = 0; c < 2; c++) begin m_pot[c] = 0; m_spk[c] = 0; m_refr[c] = 0; end
    end else if (reset_nn) begin
      for (int c = 0; c < 2; c++) begin m_pot[c] = 0; m_spk[c] = 0; m_refr[c] = 0; end
    end else if (config_en) begin
      for (int j = 18; j > 0; j--) m_chain[j] = m_chain[j-1];
      m_chain[0] = int'(bs_in);
      for (int c = 0; c < 2; c++) m_spk[c] = 0;
    end else begin
      m_ut  = field(12, 4);
      m_sel = field(16, 3);
      for (int c = 0; c < 2; c++) begin
        m_sum = 0;
        if (m_refr[c] == 0)
          for (int i = 0; i < 4; i++) if (spike_in[i]) m_sum += weight(i);
        m_p = m_pot[c] + m_sum;
        if (m_sel < 8 && clockbus[m_sel]) begin
          if (m_p > 0) m_p--;
          else if (m_p < 0) m_p++;
        end
        if (m_p > 31)  m_p = 31;
        if (m_p < -32) m_p = -32;
        if (m_refr[c] == 0 && m_p >= m_ut) begin
          m_spk[c] = 1; m_pot[c] = 0; m_refr[c] = m_refract[c];
        end else begin
          m_spk[c] = 0; m_pot[c] = m_p;
          if (m_refr[c] > 0) m_refr[c]--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pot_c0",   int'(dut.r_pot),   m_pot[0]);
      check("pot_c1",   int'(dut_r.r_pot), m_pot[1]);
      check("spike_c0", int'(spk0),        m_spk[0]);
      check("spike_c1", int'(spk1),        m_spk[1]);
      check("bsout_c0", int'(bs_out0),     m_chain[18]);
      check("bsout_c1", int'(bs_out1),     m_chain[18]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic shift_cfg(input logic [18:0] v);
    config_en = 1'b1;
    for (int k = 0; k < 19; k++) begin
      bs_in = v[k];
      tick();
    end
    config_en = 1'b0;
    bs_in = 1'b0;
  endtask

  function automatic logic [18:0] pack(input int w0, input int w1, input int w2,
                                       input int w3, input int ut, input int sel);
    return {3'(w0), 3'(w1), 3'(w2), 3'(w3), 4'(ut), 3'(sel)};
  endfunction

  logic [18:0] v1, v2;
  int exp_r [6] = '{1, 0, 0, 1, 0, 0};

  initial begin
    rst_n = 1'b0; config_en = 1'b0; reset_nn = 1'b0; bs_in = 1'b0;
    clockbus = '0; spike_in = '0;
    #12;
    check("rst_pot",   int'(dut.r_pot), 0);
    check("rst_spike", int'(spk0),      0);
    check("rst_bsout", int'(bs_out0),   0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Chain load and readback
    v1 = pack(3, 0, 0, 0, 5, 0);
    shift_cfg(v1);
    check("cfg_vec", int'(dut.w_cfg), int'(19'b011_000_000_000_0101_000));
    check("cfg_w0",  int'(dut.w_wt[0]), 3);
    check("cfg_ut",  int'(dut.w_ut), 5);
    check("cfg_sel", int'(dut.w_sel), 0);
    config_en = 1'b1;
    bs_in = 1'b0;
    for (int k = 0; k < 19; k++) begin
      check("readback", int'(bs_out0), int'(v1[k]));
      tick();
    end
    config_en = 1'b0;

    // Integrate and fire
    shift_cfg(v1);
    reset_nn = 1'b1; tick(); reset_nn = 1'b0;
    spike_in = 4'b0001;
    tick();
    check("int_pot1", int'(dut.r_pot), 3);
    check("int_spk1", int'(spk0), 0);
    tick();
    check("fire_spk", int'(spk0), 1);
    check("fire_pot", int'(dut.r_pot), 0);
    spike_in = 4'b0000;
    tick();
    check("post_spk", int'(spk0), 0);

    // reset_nn beats config_en
    spike_in = 4'b0001;
    tick();
    check("pri_pre", int'(dut.r_pot), 3);
    spike_in = 4'b0000; config_en = 1'b1; reset_nn = 1'b1; bs_in = 1'b1;
    tick();
    config_en = 1'b0; reset_nn = 1'b0; bs_in = 1'b0;
    check("pri_pot", int'(dut.r_pot), 0);
    check("pri_cfg", int'(dut.w_cfg), int'(19'b011_000_000_000_0101_000));

    // Inhibit, saturate, decay
    v2 = pack(0, -4, 0, 0, 5, 1);
    shift_cfg(v2);
    reset_nn = 1'b1; tick(); reset_nn = 1'b0;
    clockbus = 8'b0000_0010;
    spike_in = 4'b0010;
    tick();
    check("inh_pot1", int'(dut.r_pot), -3);
    for (int k = 0; k < 9; k++) tick();
    check("inh_pot10", int'(dut.r_pot), -30);
    tick(); tick();
    check("inh_sat", int'(dut.r_pot), -32);
    check("inh_spk", int'(spk0), 0);
    spike_in = 4'b0000;
    tick();
    check("dec_pot1", int'(dut.r_pot), -31);
    for (int k = 0; k < 31; k++) tick();
    check("dec_zero", int'(dut.r_pot), 0);
    for (int k = 0; k < 3; k++) tick();
    check("dec_hold", int'(dut.r_pot), 0);

    // Async reset mid-run
    spike_in = 4'b0010;
    tick(); tick();
    check("arst_pre", int'(dut.r_pot), -6);
    check("arst_bs1", int'(bs_out0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pot", int'(dut.r_pot), 0);
    check("arst_bs",  int'(bs_out0), 0);
    rst_n = 1'b1;
    spike_in = 4'b0000; clockbus = '0;

    // Refractory: all-zero configuration means uT=0, no weights
    reset_nn = 1'b1; tick(); reset_nn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("refr_pat", int'(spk1), exp_r[k]);
      check("norefr",   int'(spk0), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_spk", int'(spk0), 0);
    rst_n = 1'b1;

    tick();
    chk_en = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
